// File: rtl/gdma_link_pkg.sv
// Shared link-layer definitions for the GTP framer and the receive-side deframer:
// K-code words, frame word types and framer states.
package gdma_link_pkg;

   localparam logic [7:0]  SOF_K     = 8'hFB;
   localparam logic [7:0]  EOF_K     = 8'hFD;
   localparam logic [31:0] IDLE_WORD = 32'h1C1C1CBC;

   typedef enum logic [2:0] {
      W_IDLE,
      W_SOF,
      W_PAYLOAD,
      W_CHK,
      W_EOF
   } word_type_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PAYLOAD,
      S_CHK,
      S_EOF,
      S_DRAIN,
      S_GAP
   } state_e;

endpackage

// File: rtl/gdma_gtp_framer.sv
// Wraps tlast-delimited AXI-Stream packets into SOF/payload/CHK/EOF link frames
// for the GTP transmitter, with K28.5 idle fill and a minimum inter-frame gap.
module gdma_gtp_framer #(
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned MIN_IFG   = 2,
   parameter logic [31:0] IDLE_WORD = gdma_link_pkg::IDLE_WORD,
   parameter logic [7:0]  SOF_K     = gdma_link_pkg::SOF_K,
   parameter logic [7:0]  EOF_K     = gdma_link_pkg::EOF_K
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic [31:0] s_tdata,
   input  logic        s_tlast,
   input  logic        link_up,
   output logic [31:0] gtp_txdata,
   output logic [3:0]  gtp_txcharisk,
   output logic        frame_done,
   output logic        frame_abort,
   output logic        frame_trunc,
   output logic [31:0] frames_sent
);
   import gdma_link_pkg::*;

   localparam logic [22:0] MAX_CNT = 23'(MAX_WORDS);
   localparam logic [7:0]  MIN_GAP = 8'(MIN_IFG);

   state_e      state, state_nxt;
   word_type_e  wtype;
   logic [15:0] seq, seq_nxt;
   logic [31:0] chk, chk_nxt;
   logic [22:0] count, count_nxt;
   logic        trunc, trunc_nxt;
   logic [7:0]  gap, gap_nxt;
   logic        done_nxt, abort_nxt, trunc_pulse_nxt;
   logic [31:0] word_nxt;
   logic [3:0]  isk_nxt;

   assign s_tready = (state == S_PAYLOAD) ? link_up : (state == S_DRAIN);

   always_comb begin
      state_nxt       = state;
      seq_nxt         = seq;
      chk_nxt         = chk;
      count_nxt       = count;
      trunc_nxt       = trunc;
      gap_nxt         = gap;
      wtype           = W_IDLE;
      done_nxt        = 1'b0;
      abort_nxt       = 1'b0;
      trunc_pulse_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (s_tvalid && link_up && gap >= MIN_GAP) begin
               wtype     = W_SOF;
               seq_nxt   = seq + 16'd1;
               chk_nxt   = '0;
               count_nxt = '0;
               trunc_nxt = 1'b0;
               state_nxt = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            // The tlast beat cannot have been taken yet, so an abort always drains
            if (!link_up) begin
               abort_nxt = 1'b1;
               gap_nxt   = '0;
               state_nxt = S_DRAIN;
            end else if (s_tvalid) begin
               wtype     = W_PAYLOAD;
               chk_nxt   = chk ^ s_tdata;
               count_nxt = count + 23'd1;
               if (s_tlast) begin
                  state_nxt = S_CHK;
               end else if (count_nxt == MAX_CNT) begin
                  trunc_nxt = 1'b1;
                  state_nxt = S_CHK;
               end
            end
         end
         S_CHK, S_EOF: begin
            // A truncated frame still has the rest of its packet upstream
            if (!link_up) begin
               abort_nxt = 1'b1;
               gap_nxt   = '0;
               state_nxt = trunc ? S_DRAIN : S_GAP;
            end else if (state == S_CHK) begin
               wtype     = W_CHK;
               state_nxt = S_EOF;
            end else begin
               wtype           = W_EOF;
               done_nxt        = 1'b1;
               trunc_pulse_nxt = trunc;
               gap_nxt         = '0;
               state_nxt       = trunc ? S_DRAIN : S_GAP;
            end
         end
         S_DRAIN: begin
            if (s_tvalid && s_tlast) state_nxt = S_GAP;
         end
         S_GAP: begin
            gap_nxt = gap + 8'd1;
            if (gap_nxt >= MIN_GAP) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      word_nxt = IDLE_WORD;
      isk_nxt  = 4'b0001;
      case (wtype)
         W_SOF:     begin word_nxt = {seq, 8'h00, SOF_K};    isk_nxt = 4'b0001; end
         W_PAYLOAD: begin word_nxt = s_tdata;                isk_nxt = 4'b0000; end
         W_CHK:     begin word_nxt = chk;                    isk_nxt = 4'b0000; end
         W_EOF:     begin word_nxt = {trunc, count, EOF_K};  isk_nxt = 4'b0001; end
         default:   begin word_nxt = IDLE_WORD;              isk_nxt = 4'b0001; end
      endcase
   end

   // Control and output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         seq           <= '0;
         trunc         <= 1'b0;
         gap           <= 8'hFF;
         gtp_txdata    <= IDLE_WORD;
         gtp_txcharisk <= 4'b0001;
         frame_done    <= 1'b0;
         frame_abort   <= 1'b0;
         frame_trunc   <= 1'b0;
         frames_sent   <= '0;
      end else begin
         state         <= state_nxt;
         seq           <= seq_nxt;
         trunc         <= trunc_nxt;
         gap           <= gap_nxt;
         gtp_txdata    <= word_nxt;
         gtp_txcharisk <= isk_nxt;
         frame_done    <= done_nxt;
         frame_abort   <= abort_nxt;
         frame_trunc   <= trunc_pulse_nxt;
         frames_sent   <= frames_sent + {31'd0, done_nxt};
      end
   end

   // Checksum and count are cleared on every SOF before use
   always_ff @(posedge clk) begin
      chk   <= chk_nxt;
      count <= count_nxt;
   end

endmodule
